// File: rtl/ldm_ctrl.sv
// ldm_ctrl: LDM/STM multi-register transfer sequencer for the execute stage.
// Optional base write-back cycle is enabled by defining LDM_CTRL_BASEWB_EN.
module ldm_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_reg_list,
    input  logic        i_up,
    input  logic        i_pre,
    input  logic        i_load,
    input  logic        i_wb,
    input  logic [3:0]  i_base_code,
    input  logic        i_mem_hold,
    input  logic [31:0] i_rf_data,
    output logic [3:0]  o_rf_code,
    output logic        o_ldm_vld,
    output logic [31:0] o_ldm_offset,
    output logic        o_ldm_mem_vld,
    output logic [3:0]  o_ldm_reg_code,
    output logic [31:0] o_ldm_reg,
    output logic        o_ldm_load,
    output logic        o_stall,
    output logic        o_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_BASEWB = 2'd2
    } state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[3:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t      state_r;
    logic [15:0] rem_r;
    logic [31:0] offset_r;
    logic        load_r;
    logic        empty_done_r;

    logic [4:0]  n_s;
    logic [31:0] four_n_s;
    logic [31:0] init_off_s;
    logic [15:0] rem_next_s;
    logic        last_s;
    logic        idle_s;
    logic        accept_s;
    logic        wb_go_s;

`ifdef LDM_CTRL_BASEWB_EN
    logic        up_r;
    logic        wb_r;
    logic [3:0]  base_r;
    logic [4:0]  cnt_r;
    logic [31:0] wb_off_s;

    assign wb_go_s  = wb_r;
    assign wb_off_s = up_r ? {25'd0, cnt_r, 2'b00} : (32'd0 - {25'd0, cnt_r, 2'b00});
`else
    logic unused_s;

    // W and base only matter when the write-back cycle exists
    assign unused_s = ^{i_wb, i_base_code};
    assign wb_go_s  = 1'b0;
`endif

    assign n_s        = popcount16(i_reg_list);
    assign four_n_s   = {25'd0, n_s, 2'b00};
    assign rem_next_s = rem_r & (rem_r - 16'd1);
    assign last_s     = (rem_next_s == 16'd0);
    assign idle_s     = (state_r == ST_IDLE);
    assign accept_s   = (state_r == ST_XFER) && !i_mem_hold;

    // Starting offset: decrement modes begin 4n below the base so addresses still ascend
    always_comb begin
        init_off_s = 32'd0;
        if (i_up) begin
            init_off_s = i_pre ? 32'd4 : 32'd0;
        end else begin
            init_off_s = i_pre ? (32'd0 - four_n_s) : (32'd4 - four_n_s);
        end
    end

    // Sequencer state, remaining list, offset and latched instruction fields
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            rem_r        <= 16'd0;
            offset_r     <= 32'd0;
            load_r       <= 1'b0;
            empty_done_r <= 1'b0;
`ifdef LDM_CTRL_BASEWB_EN
            up_r         <= 1'b0;
            wb_r         <= 1'b0;
            base_r       <= 4'd0;
            cnt_r        <= 5'd0;
`endif
        end else begin
            empty_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        rem_r    <= i_reg_list;
                        offset_r <= init_off_s;
                        load_r   <= i_load;
`ifdef LDM_CTRL_BASEWB_EN
                        up_r     <= i_up;
                        wb_r     <= i_wb;
                        base_r   <= i_base_code;
                        cnt_r    <= n_s;
`endif
                        if (n_s == 5'd0) begin
                            empty_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (accept_s) begin
                        rem_r    <= rem_next_s;
                        offset_r <= offset_r + 32'd4;
                        if (last_s) begin
`ifdef LDM_CTRL_BASEWB_EN
                            if (wb_go_s) begin
                                state_r  <= ST_BASEWB;
                                offset_r <= wb_off_s;
                            end else begin
                                state_r <= ST_IDLE;
                            end
`else
                            state_r <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_BASEWB: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; everything reads 0 while idle
    always_comb begin
        o_ldm_vld      = 1'b0;
        o_ldm_mem_vld  = 1'b0;
        o_ldm_reg_code = 4'd0;
        o_ldm_offset   = 32'd0;
        o_ldm_load     = 1'b0;
        case (state_r)
            ST_XFER: begin
                o_ldm_vld      = 1'b1;
                o_ldm_mem_vld  = 1'b1;
                o_ldm_reg_code = lowest_idx(rem_r);
                o_ldm_offset   = offset_r;
                o_ldm_load     = load_r;
            end
`ifdef LDM_CTRL_BASEWB_EN
            ST_BASEWB: begin
                o_ldm_vld      = 1'b1;
                o_ldm_reg_code = base_r;
                o_ldm_offset   = offset_r;
                o_ldm_load     = load_r;
            end
`endif
            default: begin
                o_ldm_vld = 1'b0;
            end
        endcase
    end

    assign o_rf_code = o_ldm_reg_code;
    assign o_ldm_reg = i_rf_data;
    assign o_stall   = (i_start && idle_s) || o_ldm_vld;
    assign o_done    = (accept_s && last_s && !wb_go_s)
                     || (state_r == ST_BASEWB)
                     || empty_done_r;

endmodule

// File: tb/tb_ldm_ctrl.sv
// Directed self-checking bench for ldm_ctrl; cycle-by-cycle hand-computed expectations.
module tb_ldm_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] reg_list;
    logic        up, pre, load, wb;
    logic [3:0]  base_code;
    logic        mem_hold;
    logic [31:0] rf_data;
    logic [3:0]  rf_code;
    logic        ldm_vld;
    logic [31:0] ldm_offset;
    logic        ldm_mem_vld;
    logic [3:0]  ldm_reg_code;
    logic [31:0] ldm_reg;
    logic        ldm_load;
    logic        stall;
    logic        done;

    int total = 0;
    int bad   = 0;

    ldm_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_reg_list     (reg_list),
        .i_up           (up),
        .i_pre          (pre),
        .i_load         (load),
        .i_wb           (wb),
        .i_base_code    (base_code),
        .i_mem_hold     (mem_hold),
        .i_rf_data      (rf_data),
        .o_rf_code      (rf_code),
        .o_ldm_vld      (ldm_vld),
        .o_ldm_offset   (ldm_offset),
        .o_ldm_mem_vld  (ldm_mem_vld),
        .o_ldm_reg_code (ldm_reg_code),
        .o_ldm_reg      (ldm_reg),
        .o_ldm_load     (ldm_load),
        .o_stall        (stall),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, ".vld"},    {31'd0, ldm_vld},     32'd0);
        chk({tag, ".memvld"}, {31'd0, ldm_mem_vld}, 32'd0);
        chk({tag, ".code"},   {28'd0, ldm_reg_code}, 32'd0);
        chk({tag, ".rfcode"}, {28'd0, rf_code},     32'd0);
        chk({tag, ".off"},    ldm_offset,           32'd0);
        chk({tag, ".load"},   {31'd0, ldm_load},    32'd0);
    endtask

    task automatic chk_xfer(input string tag, input logic [3:0] code, input logic [31:0] off,
                            input logic dn, input logic ld);
        #1;
        chk({tag, ".vld"},    {31'd0, ldm_vld},      32'd1);
        chk({tag, ".memvld"}, {31'd0, ldm_mem_vld},  32'd1);
        chk({tag, ".code"},   {28'd0, ldm_reg_code}, {28'd0, code});
        chk({tag, ".rfcode"}, {28'd0, rf_code},      {28'd0, code});
        chk({tag, ".off"},    ldm_offset,            off);
        chk({tag, ".done"},   {31'd0, done},         {31'd0, dn});
        chk({tag, ".load"},   {31'd0, ldm_load},     {31'd0, ld});
        chk({tag, ".stall"},  {31'd0, stall},        32'd1);
    endtask

    task automatic issue(input logic [15:0] lst, input logic u, input logic p, input logic l,
                         input logic w, input logic [3:0] b);
        start = 1'b1; reg_list = lst; up = u; pre = p; load = l; wb = w; base_code = b;
        #1;
        chk("start.stall", {31'd0, stall}, 32'd1);
        chk("start.vld",   {31'd0, ldm_vld}, 32'd0);
        step();
        start = 1'b0; reg_list = 16'd0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reg_list = 16'd0; up = 1'b0; pre = 1'b0; load = 1'b0;
        wb = 1'b0; base_code = 4'd0; mem_hold = 1'b0; rf_data = 32'd0;
        step();
        step();
        chk_idle("reset");
        chk("reset.done",  {31'd0, done},  32'd0);
        chk("reset.stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        step();

        // LDMIA 0x000E
        issue(16'h000E, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        chk_xfer("ia1", 4'd1, 32'd0, 1'b0, 1'b1); step();
        chk_xfer("ia2", 4'd2, 32'd4, 1'b0, 1'b1); step();
        chk_xfer("ia3", 4'd3, 32'd8, 1'b1, 1'b1); step();
        chk_idle("ia.end");
        chk("ia.end.done",  {31'd0, done},  32'd0);
        chk("ia.end.stall", {31'd0, stall}, 32'd0);

        // STMDB 0x4010, store data passes through
        issue(16'h4010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        rf_data = 32'hA5A5_0004;
        chk_xfer("db1", 4'd4, 32'hFFFF_FFF8, 1'b0, 1'b0);
        chk("db1.data", ldm_reg, 32'hA5A5_0004); step();
        rf_data = 32'h1234_000E;
        chk_xfer("db2", 4'd14, 32'hFFFF_FFFC, 1'b1, 1'b0);
        chk("db2.data", ldm_reg, 32'h1234_000E); step();
        rf_data = 32'd0;
        chk_idle("db.end");

        // IB 0x8001
        issue(16'h8001, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        chk_xfer("ib1", 4'd0,  32'd4, 1'b0, 1'b1); step();
        chk_xfer("ib2", 4'd15, 32'd8, 1'b1, 1'b1); step();
        chk_idle("ib.end");

        // DA 0x0003
        issue(16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk_xfer("da1", 4'd0, 32'hFFFF_FFFC, 1'b0, 1'b1); step();
        chk_xfer("da2", 4'd1, 32'd0,         1'b1, 1'b1); step();
        chk_idle("da.end");

        // LDMIA 0x0007 with two hold cycles on the second transfer
        issue(16'h0007, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        chk_xfer("hd1", 4'd0, 32'd0, 1'b0, 1'b1); step();
        mem_hold = 1'b1;
        chk_xfer("hd2", 4'd1, 32'd4, 1'b0, 1'b1); step();
        chk_xfer("hd3", 4'd1, 32'd4, 1'b0, 1'b1); step();
        mem_hold = 1'b0;
        chk_xfer("hd4", 4'd1, 32'd4, 1'b0, 1'b1); step();
        chk_xfer("hd5", 4'd2, 32'd8, 1'b1, 1'b1); step();
        chk_idle("hd.end");

        // Empty list
        issue(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        chk_idle("em1");
        chk("em1.done",  {31'd0, done},  32'd1);
        chk("em1.stall", {31'd0, stall}, 32'd0);
        step();
        chk_idle("em2");
        chk("em2.done", {31'd0, done}, 32'd0);

        // Reset in the middle of a 4-register LDM
        issue(16'h000F, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        chk_xfer("rs1", 4'd0, 32'd0, 1'b0, 1'b1); step();
        rst = 1'b1;
        chk_xfer("rs2", 4'd1, 32'd4, 1'b0, 1'b1); step();
        rst = 1'b0;
        chk_idle("rs3");
        chk("rs3.done",  {31'd0, done},  32'd0);
        chk("rs3.stall", {31'd0, stall}, 32'd0);
        chk("rs3.data",  ldm_reg,        32'd0);
        step();

        // LDMDB W=1 list 0x0700 base 13
        issue(16'h0700, 1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
        chk_xfer("wb1", 4'd8,  32'hFFFF_FFF4, 1'b0, 1'b1); step();
        chk_xfer("wb2", 4'd9,  32'hFFFF_FFF8, 1'b0, 1'b1); step();
`ifdef LDM_CTRL_BASEWB_EN
        chk_xfer("wb3", 4'd10, 32'hFFFF_FFFC, 1'b0, 1'b1); step();
        mem_hold = 1'b1;
        #1;
        chk("wb4.vld",    {31'd0, ldm_vld},      32'd1);
        chk("wb4.memvld", {31'd0, ldm_mem_vld},  32'd0);
        chk("wb4.code",   {28'd0, ldm_reg_code}, 32'd13);
        chk("wb4.off",    ldm_offset,            32'hFFFF_FFF4);
        chk("wb4.done",   {31'd0, done},         32'd1);
        step();
        mem_hold = 1'b0;
`else
        chk_xfer("wb3", 4'd10, 32'hFFFF_FFFC, 1'b1, 1'b1); step();
`endif
        chk_idle("wb.end");
        chk("wb.end.done", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
